mdu_process: RTL and testbench
==============================

// Module: mdu_process
// PURPOSE
// - Successor of the single-cycle process stage: fronts the existing ALU and adds the
//   multi-cycle MUL AB / DIV AB datapath behind the reserved opcode alu_op == 4'hf.
// - ALU ops (alu_op != 4'hf) stay combinational pass-through. Multi-cycle ops run as an
//   iterative shift-add multiplier / restoring divider with a start/busy/done handshake.
// - Sits in the CPU execute stage; the controller stalls on busy.
// PARAMETERS
// - WIDTH    8  operand width; product/dividend widths derive from it (2*WIDTH product)
// - CY_BIT   7  PSW carry bit index
// - OV_BIT   2  PSW overflow bit index
// - P_BIT    0  PSW parity bit index
// PORTS
// - clk           in   1      system clock, rising edge
// - rst_n         in   1      asynchronous active-low reset
// - psw_in        in   8      current PSW
// - a_data        in   WIDTH  operand A (multiplicand / dividend)
// - b_data        in   WIDTH  operand B (multiplier / divisor)
// - bit_location  in   3      bit index for ALU bit ops
// - alu_op        in   4      ALU opcode; 4'hf selects the multi-cycle unit
// - mdu_op        in   1      0 = MUL, 1 = DIV; sampled with start
// - start         in   1      request; accepted only in IDLE with alu_op == 4'hf
// - ans           out  WIDTH  result A (ALU result, or MUL low / DIV quotient)
// - ans_b         out  WIDTH  result B (MUL high / DIV remainder); 0 for ALU ops
// - psw_out       out  8      updated PSW
// - busy          out  1      high while an operation is in progress (RUN and DONE)
// - done          out  1      one-cycle pulse: results valid and registered
// BEHAVIOUR
// - Reset (async, rst_n low): state=IDLE, busy=0, done=0, result/PSW/operand regs=0,
//   counter=0. Reset mid-operation aborts; no done pulse follows.
// - Output mux: alu_op != 4'hf -> ans/psw_out from ALU combinationally, ans_b=0;
//   alu_op == 4'hf -> registered res_a/res_b/res_psw (hold last result until next start).
// - FSM IDLE->RUN on accepted start (captures a_data, b_data, psw_in, mdu_op; count=0).
//   RUN: one iteration per clock; after WIDTH iterations -> DONE. DONE: done=1 for one
//   cycle, results written, -> IDLE. DIV with b_data==0: IDLE->DONE directly.
// - Latency: done high in the cycle after the (WIDTH+1)th rising edge counted from the
//   edge sampling start (9 edges at WIDTH=8); divide-by-zero: 1 edge.
// - start while busy, or start with alu_op != 4'hf: ignored, no state change.
// - start in the DONE cycle: ignored; a new start is accepted the following IDLE cycle.
// - MUL: {res_b,res_a} = A*B (2*WIDTH bits, unsigned). OV=1 iff res_b != 0.
// - DIV: res_a = A/B, res_b = A%B (unsigned). OV=0. Div-by-zero: OV=1, res_a=A, res_b=B.
// - res_psw: captured psw with CY=0, OV per above, P = ^res_a (odd parity -> 1); other
//   bits unchanged. ALU-path PSW semantics are those of the ALU, unchanged.
// - All arithmetic unsigned; multiplier accumulator WIDTH+1 bits to hold carry; divider
//   partial remainder WIDTH+1 bits for the trial subtract.
// STRUCTURE
// - Shared package: ALU_OP_MDU=4'hf, MDU_MUL=1'b0/MDU_DIV=1'b1, PSW bit indices, FSM
//   state encoding (IDLE/RUN/DONE).
// - Sub-module: existing ALU instantiated unchanged; mdu_core (FSM + iterative datapath)
//   is the one natural sub-module, the top holds only the output mux.
// TESTING
// - MUL A=0x50 B=0xA0 -> done after 9 edges; ans=0x00, ans_b=0x32, OV=1, CY=0, P=0.
// - DIV A=0xFB B=0x12 -> done after 9 edges; ans=0x0D, ans_b=0x11, OV=0, CY=0, P=1.
// - DIV A=0x12 B=0x00 -> done after 1 edge; ans=0x12, ans_b=0x00, OV=1, CY=0.
// - MUL 0xFF*0xFF with start re-pulsed each RUN cycle -> single done; ans=0x01, ans_b=0xFE.
// - rst_n low at RUN iteration 4 -> busy=0, done=0, ans=0 (alu_op=4'hf) immediately;
//   fresh MUL 0x03*0x04 -> ans=0x0C, ans_b=0x00, OV=0.
// - alu_op=ADD (non-4'hf) during busy -> ans/psw_out track ALU combinationally, ans_b=0;
//   pending multi-cycle op still completes with correct registered results.

Source files
------------

// File: rtl/mdu_process_pkg.sv
// Shared opcodes, MDU operation codes and FSM state encoding for the
// execute-stage process block (ALU front end plus iterative MUL/DIV unit).
package mdu_process_pkg;

  localparam logic [3:0] ALU_OP_MDU = 4'hf;

  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;

  localparam int CY_BIT_DEF = 7;
  localparam int OV_BIT_DEF = 2;
  localparam int P_BIT_DEF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_ADDC  = 4'h1,
    ALU_SUBB  = 4'h2,
    ALU_INC   = 4'h3,
    ALU_DEC   = 4'h4,
    ALU_ANL   = 4'h5,
    ALU_ORL   = 4'h6,
    ALU_XRL   = 4'h7,
    ALU_CPL   = 4'h8,
    ALU_RL    = 4'h9,
    ALU_RR    = 4'ha,
    ALU_SETB  = 4'hb,
    ALU_CLRB  = 4'hc,
    ALU_CPLB  = 4'hd,
    ALU_PASSB = 4'he
  } alu_op_e;

endpackage

// File: rtl/mdu_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with a
// start/busy/done handshake; one iteration per clock, WIDTH iterations.
module mdu_core
  import mdu_process_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CY_BIT = CY_BIT_DEF,
  parameter int OV_BIT = OV_BIT_DEF,
  parameter int P_BIT  = P_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_alu_op,
  input  logic             i_mdu_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [7:0]       i_psw,
  output logic [WIDTH-1:0] o_res_a,
  output logic [WIDTH-1:0] o_res_b,
  output logic [7:0]       o_res_psw,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e       r_state, w_state_nxt;
  logic             r_mdu_op;
  logic [WIDTH-1:0] r_m;     // multiplicand / divisor
  logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier -> product low half / dividend -> quotient
  logic [7:0]       r_psw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res_a, r_res_b;
  logic [7:0]       r_res_psw;

  logic             w_accept, w_div0, w_last, w_write;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_trial;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_nxt_acc, w_nxt_q;
  logic [WIDTH-1:0] w_fin_a, w_fin_b;
  logic [7:0]       w_fin_psw;
  logic             w_fin_ov;

  assign w_accept = (r_state == ST_IDLE) && i_start && (i_alu_op == ALU_OP_MDU);
  assign w_div0   = (i_mdu_op == MDU_DIV) && (i_b == '0);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST_CNT);
  assign w_write  = w_last || (w_accept && w_div0);

  // Carry out of the add lands in the top bit and is shifted into the high half.
  assign w_mul_sum   = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_m}) : {1'b0, r_acc};
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_m};
  assign w_div_ok    = ~w_div_trial[WIDTH];

  always_comb begin
    if (r_mdu_op == MDU_MUL) begin
      w_nxt_acc = w_mul_sum[WIDTH:1];
      w_nxt_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end else begin
      w_nxt_acc = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_nxt_q   = {r_q[WIDTH-2:0], w_div_ok};
    end
  end

  // Divide-by-zero finishes straight from IDLE using the live inputs.
  always_comb begin
    w_fin_a   = w_nxt_q;
    w_fin_b   = w_nxt_acc;
    w_fin_psw = r_psw;
    w_fin_ov  = (r_mdu_op == MDU_MUL) && (w_nxt_acc != '0);
    if (r_state == ST_IDLE) begin
      w_fin_a   = i_a;
      w_fin_b   = i_b;
      w_fin_psw = i_psw;
      w_fin_ov  = 1'b1;
    end
    w_fin_psw[CY_BIT] = 1'b0;
    w_fin_psw[OV_BIT] = w_fin_ov;
    w_fin_psw[P_BIT]  = ^w_fin_a;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_div0 ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdu_op  <= MDU_MUL;
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_psw     <= '0;
      r_cnt     <= '0;
      r_res_a   <= '0;
      r_res_b   <= '0;
      r_res_psw <= '0;
    end else begin
      if (w_accept) begin
        r_mdu_op <= i_mdu_op;
        r_m      <= i_b;
        r_acc    <= '0;
        r_q      <= i_a;
        r_psw    <= i_psw;
        r_cnt    <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_nxt_acc;
        r_q   <= w_nxt_q;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_write) begin
        r_res_a   <= w_fin_a;
        r_res_b   <= w_fin_b;
        r_res_psw <= w_fin_psw;
      end
    end
  end

  assign o_res_a   = r_res_a;
  assign o_res_b   = r_res_b;
  assign o_res_psw = r_res_psw;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);

endmodule

// File: rtl/mdu_process_alu.sv
// Single-cycle combinational ALU of the execute stage: arithmetic, logic,
// rotate and bit ops, updating CY/OV/P in the PSW.
module mdu_process_alu
  import mdu_process_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CY_BIT = CY_BIT_DEF,
  parameter int OV_BIT = OV_BIT_DEF,
  parameter int P_BIT  = P_BIT_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_bit_loc,
  input  logic [3:0]       i_op,
  input  logic [7:0]       i_psw,
  output logic [WIDTH-1:0] o_result,
  output logic [7:0]       o_psw
);

  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_ov;

  assign w_cin  = i_psw[CY_BIT] & ((i_op == ALU_ADDC) | (i_op == ALU_SUBB));
  assign w_mask = WIDTH'(1) << i_bit_loc;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_res = i_a;
    w_cy  = i_psw[CY_BIT];
    w_ov  = i_psw[OV_BIT];
    w_sum = '0;
    case (i_op)
      ALU_ADD, ALU_ADDC: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(w_cin);
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
        w_ov  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUBB: begin
        w_sum = {1'b0, i_a} - {1'b0, i_b} - (WIDTH+1)'(w_cin);
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
        w_ov  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_INC:   w_res = i_a + WIDTH'(1);
      ALU_DEC:   w_res = i_a - WIDTH'(1);
      ALU_ANL:   w_res = i_a & i_b;
      ALU_ORL:   w_res = i_a | i_b;
      ALU_XRL:   w_res = i_a ^ i_b;
      ALU_CPL:   w_res = ~i_a;
      ALU_RL:    w_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      ALU_RR:    w_res = {i_a[0], i_a[WIDTH-1:1]};
      ALU_SETB:  w_res = i_a | w_mask;
      ALU_CLRB:  w_res = i_a & ~w_mask;
      ALU_CPLB:  w_res = i_a ^ w_mask;
      ALU_PASSB: w_res = i_b;
      default:   w_res = i_a;
    endcase
  end

  always_comb begin
    o_result      = w_res;
    o_psw         = i_psw;
    o_psw[CY_BIT] = w_cy;
    o_psw[OV_BIT] = w_ov;
    o_psw[P_BIT]  = ^w_res;
  end

endmodule

// File: rtl/mdu_process.sv
// Execute-stage process block: combinational ALU for ordinary opcodes, the
// multi-cycle MUL/DIV unit's registered results behind opcode 4'hf.
module mdu_process
  import mdu_process_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CY_BIT = CY_BIT_DEF,
  parameter int OV_BIT = OV_BIT_DEF,
  parameter int P_BIT  = P_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       psw_in,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [2:0]       bit_location,
  input  logic [3:0]       alu_op,
  input  logic             mdu_op,
  input  logic             start,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_b,
  output logic [7:0]       psw_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] w_alu_res, w_res_a, w_res_b;
  logic [7:0]       w_alu_psw, w_res_psw;

  mdu_process_alu #(
    .WIDTH (WIDTH), .CY_BIT(CY_BIT), .OV_BIT(OV_BIT), .P_BIT(P_BIT)
  ) u_alu (
    .i_a      (a_data),
    .i_b      (b_data),
    .i_bit_loc(bit_location),
    .i_op     (alu_op),
    .i_psw    (psw_in),
    .o_result (w_alu_res),
    .o_psw    (w_alu_psw)
  );

  mdu_core #(
    .WIDTH (WIDTH), .CY_BIT(CY_BIT), .OV_BIT(OV_BIT), .P_BIT(P_BIT)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .i_alu_op (alu_op),
    .i_mdu_op (mdu_op),
    .i_a      (a_data),
    .i_b      (b_data),
    .i_psw    (psw_in),
    .o_res_a  (w_res_a),
    .o_res_b  (w_res_b),
    .o_res_psw(w_res_psw),
    .o_busy   (busy),
    .o_done   (done)
  );

  always_comb begin
    if (alu_op == ALU_OP_MDU) begin
      ans     = w_res_a;
      ans_b   = w_res_b;
      psw_out = w_res_psw;
    end else begin
      ans     = w_alu_res;
      ans_b   = '0;
      psw_out = w_alu_psw;
    end
  end

endmodule

// File: tb/tb_mdu_process.sv
// Directed self-checking bench for mdu_process: reset, MUL, DIV, divide-by-zero,
// start re-pulsing, reset abort and ALU pass-through while the unit is busy.
module tb_mdu_process;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] psw_in, a_data, b_data;
  logic [2:0] bit_location;
  logic [3:0] alu_op;
  logic       mdu_op, start;
  logic [7:0] ans, ans_b, psw_out;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] OP_MDU = 4'hf;
  localparam logic [3:0] OP_ADD = 4'h0;

  mdu_process dut (
    .clk(clk), .rst_n(rst_n), .psw_in(psw_in), .a_data(a_data), .b_data(b_data),
    .bit_location(bit_location), .alu_op(alu_op), .mdu_op(mdu_op), .start(start),
    .ans(ans), .ans_b(ans_b), .psw_out(psw_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and count edges until done is seen (-1 on timeout).
  task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] psw, output int edges);
    alu_op = OP_MDU; mdu_op = op; a_data = a; b_data = b; psw_in = psw; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    if (done !== 1'b1) edges = -1;
  endtask

  task automatic check_result(input string name, input int edges, input int exp_edges,
                              input logic [7:0] exp_a, input logic [7:0] exp_b,
                              input logic [7:0] exp_psw);
    vectors++;
    if (edges !== exp_edges) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, exp_edges);
    end
    vectors++;
    if (ans !== exp_a) begin
      miscompares++;
      $display("FAIL %s ans: got %h, expected %h", name, ans, exp_a);
    end
    vectors++;
    if (ans_b !== exp_b) begin
      miscompares++;
      $display("FAIL %s ans_b: got %h, expected %h", name, ans_b, exp_b);
    end
    vectors++;
    if (psw_out !== exp_psw) begin
      miscompares++;
      $display("FAIL %s psw_out: got %h, expected %h", name, psw_out, exp_psw);
    end
  endtask

  task automatic expect_idle(input string name);
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: got busy=%b done=%b, expected 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_op = OP_MDU; mdu_op = 1'b0; start = 1'b0;
    a_data = 8'h00; b_data = 8'h00; psw_in = 8'h00; bit_location = 3'd0;
    #2;
    vectors++;
    if ({busy, done, ans, ans_b, psw_out} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b ans=%h ans_b=%h psw=%h, expected all 0",
               busy, done, ans, ans_b, psw_out);
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int e;
    run_op(1'b0, 8'h50, 8'hA0, 8'hFF, e);
    check_result("mul_50xa0", e, 9, 8'h00, 8'h32, 8'h7E);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_busy_in_done: got %b, expected 1", busy);
    end
    expect_idle("mul");
    vectors++;
    if (ans_b !== 8'h32) begin
      miscompares++;
      $display("FAIL mul_hold: got ans_b=%h, expected 32", ans_b);
    end
  endtask

  task automatic test_div();
    int e;
    run_op(1'b1, 8'hFB, 8'h12, 8'h80, e);
    check_result("div_fb_12", e, 9, 8'h0D, 8'h11, 8'h01);
    expect_idle("div");
  endtask

  task automatic test_div_zero();
    int e;
    run_op(1'b1, 8'h12, 8'h00, 8'h00, e);
    check_result("div_by_zero", e, 1, 8'h12, 8'h00, 8'h04);
    expect_idle("div_by_zero");
  endtask

  task automatic test_start_ignored();
    alu_op = OP_ADD; mdu_op = 1'b0; a_data = 8'h05; b_data = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_non_mdu_op: got busy=%b, expected 0", busy);
    end
    alu_op = OP_MDU;
    #1;
    vectors++;
    if (ans !== 8'h12) begin
      miscompares++;
      $display("FAIL result_hold: got ans=%h, expected 12", ans);
    end
  endtask

  // start held high through RUN and the DONE cycle; operands change after capture.
  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1;
    logic [7:0] got_a = 8'h00, got_b = 8'h00, got_psw = 8'h00;
    alu_op = OP_MDU; mdu_op = 1'b0; a_data = 8'hFF; b_data = 8'hFF; psw_in = 8'h00;
    start = 1'b1;
    tick();
    a_data = 8'h11; b_data = 8'h22;
    for (int e = 2; e <= 20; e++) begin
      tick();
      if (e == 10) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = e; got_a = ans; got_b = ans_b; got_psw = psw_out;
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL repulse_done_count: got %0d, expected 1", pulses);
    end
    vectors++;
    if (first !== 9) begin
      miscompares++;
      $display("FAIL repulse_latency: got %0d, expected 9", first);
    end
    vectors++;
    if (got_a !== 8'h01 || got_b !== 8'hFE || got_psw !== 8'h05) begin
      miscompares++;
      $display("FAIL repulse_result: got %h %h psw %h, expected 01 fe psw 05",
               got_a, got_b, got_psw);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL repulse_start_in_done: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    logic saw_done = 1'b0;
    alu_op = OP_MDU; mdu_op = 1'b0; a_data = 8'h55; b_data = 8'h33; psw_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ans, ans_b, psw_out} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got busy=%b done=%b ans=%h ans_b=%h psw=%h, expected all 0",
               busy, done, ans, ans_b, psw_out);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort_done: got done pulse, expected none");
    end
    run_op(1'b0, 8'h03, 8'h04, 8'h00, e);
    check_result("mul_after_reset", e, 9, 8'h0C, 8'h00, 8'h00);
    expect_idle("mul_after_reset");
  endtask

  task automatic test_alu_during_busy();
    int e;
    alu_op = OP_MDU; mdu_op = 1'b0; a_data = 8'h0F; b_data = 8'h11; psw_in = 8'h7B;
    start = 1'b1;
    tick();
    start = 1'b0;
    alu_op = OP_ADD; a_data = 8'h7F; b_data = 8'h01; psw_in = 8'h00;
    #1;
    vectors++;
    if (ans !== 8'h80 || ans_b !== 8'h00 || psw_out !== 8'h05 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_add_7f_01: got ans=%h ans_b=%h psw=%h busy=%b, expected 80 00 05 1",
               ans, ans_b, psw_out, busy);
    end
    a_data = 8'hFF; b_data = 8'h02;
    #1;
    vectors++;
    if (ans !== 8'h01 || ans_b !== 8'h00 || psw_out !== 8'h81) begin
      miscompares++;
      $display("FAIL alu_add_ff_02: got ans=%h ans_b=%h psw=%h, expected 01 00 81",
               ans, ans_b, psw_out);
    end
    e = 1;
    while (done !== 1'b1 && e < 40) begin
      tick();
      e++;
    end
    if (done !== 1'b1) e = -1;
    alu_op = OP_MDU;
    #1;
    check_result("mul_under_alu", e, 9, 8'hFF, 8'h00, 8'h7A);
    expect_idle("mul_under_alu");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_alu_during_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
